dma_read_arbiter: RTL and testbench
===================================

// Module: dma_read_arbiter
// PURPOSE
//  Round-robin arbiter between two DMA read channels that share one AXI4 read port (AR + R).
//  Grants one channel per burst and drives the select of the MUX2to1 instances on the ARADDR/ARLEN path.
//  Owns ARVALID and RREADY, and holds the grant until the RLAST beat.
//  Sits in Main_FSM, between the per-channel descriptor engines and the AXI4 master interface.
// PARAMETERS
//  LEN_W   8   AXI ARLEN width; a burst has len+1 beats
//  CNT_W  16   width of the grant statistics counters (DMA_ARB_STATS_EN only)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  ch_req       in   2      per-channel burst request; held high until the matching ch_done
//  ch_len       in   2xLEN_W  per-channel ARLEN; sampled at grant for beat checking
//  ch_gnt       out  2      one-hot grant, or 0 when idle
//  mux_sel      out  1      select to the external MUX2to1 instances (0 = ch0, 1 = ch1)
//  ar_valid     out  1      AXI ARVALID
//  ar_ready     in   1      AXI ARREADY
//  r_valid      in   1      AXI RVALID
//  r_last       in   1      AXI RLAST
//  r_ready      out  1      AXI RREADY
//  ch_done      out  2      one-cycle pulse on the RLAST beat of the granted channel
//  len_err      out  1      sticky flag; set when the RLAST beat count != len+1; cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE; ch_gnt=0; mux_sel=0; ar_valid=0; r_ready=0; ch_done=0; len_err=0; last_gnt=1 (ch0 wins first).
//  FSM states: IDLE -> ADDR -> DATA -> IDLE.
//   IDLE: if ch_req!=0, choose a winner and go to ADDR. On that edge, register mux_sel, ch_gnt, lat_len and beat_cnt=0.
//     - Only one channel requests: that channel wins.
//     - Both request: winner = ~last_gnt.
//   ADDR: ar_valid=1 until ar_valid&ar_ready, then go to DATA.
//     - Once asserted, ar_valid is never withdrawn, even if ch_req drops.
//   DATA: r_ready=1. Each r_valid&r_ready beat increments beat_cnt (LEN_W+1 bits).
//     - On the beat with r_last: pulse ch_done[mux_sel]; last_gnt<=mux_sel; ch_gnt<=0; go to IDLE.
//     - If beat_cnt+1 != lat_len+1 on that beat, set len_err.
//  Latency:
//   - req seen high at edge N -> ar_valid high in cycle N+1.
//   - Min 1 IDLE cycle between bursts, so two back-to-back bursts are 1 cycle apart.
//  mux_sel and ch_gnt stay stable from ADDR entry until the RLAST beat. mux_sel keeps its last value while IDLE.
//  r_valid outside DATA is ignored (r_ready=0). ar_ready outside ADDR is ignored.
//  r_last together with ar_ready: not possible, since the states are exclusive.
//  A req that drops mid-burst does not abort the burst; ch_done still pulses.
//  rst mid-burst returns everything to reset values on the next edge; an outstanding AXI transaction is the system's responsibility.
// CONFIGURATION
//  DMA_ARB_STATS_EN defined:
//   - adds outputs ch0_gnt_cnt and ch1_gnt_cnt (each CNT_W bits).
//   - each increments on the IDLE->ADDR edge that grants that channel; saturates at all-ones; reset to 0.
//  DMA_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package dma_arb_pkg:
//   - arb_state_t enum {IDLE, ADDR, DATA}.
//   - localparam NUM_CH=2.
//  Sub-module dma_rr_pick (combinational): inputs req[1:0] and last_gnt; outputs winner and any_req.
//  The FSM, beat counter and stats counters stay in dma_read_arbiter.
//  MUX2to1 instances are external and driven by mux_sel.
// TESTING
//  1 Reset, then ch_req=01, len0=3, ar_ready=1 at once:
//    -> ar_valid one cycle later; 4 beats; ch_done=01 on beat 4; len_err=0.
//  2 ch_req=11 held, 3 bursts:
//    -> grant order ch0, ch1, ch0; mux_sel 0, 1, 0; a 1-cycle IDLE gap each time.
//  3 ch_req=10, ar_ready low for 5 cycles:
//    -> ar_valid held for 5 cycles, mux_sel=1 stable, no r_ready until the AR handshake.
//  4 len=7, RLAST on beat 5:
//    -> ch_done pulses, len_err=1 and stays 1 through later good bursts.
//  5 rst pulsed during DATA:
//    -> all outputs at reset values next cycle; the next request is granted to ch0.
//  6 STATS_EN build, 3 ch0 grants and 2 ch1 grants:
//    -> ch0_gnt_cnt=3, ch1_gnt_cnt=2.
//    -> With CNT_W=2 and 5 ch0 grants: ch0_gnt_cnt saturates at 3.

Source files
------------

// File: rtl/dma_read_arbiter_pkg.sv
// dma_arb_pkg: shared types for the two-channel DMA read arbiter.
// Used by the arbiter, its pick logic and its bus interface.
// Optional feature macro used elsewhere in this slice: DMA_ARB_STATS_EN.
package dma_arb_pkg;

   localparam int NUM_CH = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   // Turns a channel index into its one-hot grant/done vector.
   function automatic logic [NUM_CH-1:0] ch_onehot(input logic sel);
      return sel ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dma_read_arbiter_if.sv
// dma_read_arbiter_if: request/grant handshake between the descriptor engines
// and the arbiter, plus the shared AXI4 AR/R control signals.
// The master modport is the arbiter's view; the slave modport is the
// environment's view (descriptor engines and AXI port).
interface dma_read_arbiter_if
   import dma_arb_pkg::*;
#(
   parameter int LEN_W = 8
);

   logic [NUM_CH-1:0]            ch_req;
   logic [NUM_CH-1:0][LEN_W-1:0] ch_len;
   logic [NUM_CH-1:0]            ch_gnt;
   logic                         mux_sel;
   logic                         ar_valid;
   logic                         ar_ready;
   logic                         r_valid;
   logic                         r_last;
   logic                         r_ready;
   logic [NUM_CH-1:0]            ch_done;
   logic                         len_err;

   modport master (
      input  ch_req, ch_len, ar_ready, r_valid, r_last,
      output ch_gnt, mux_sel, ar_valid, r_ready, ch_done, len_err
   );

   modport slave (
      output ch_req, ch_len, ar_ready, r_valid, r_last,
      input  ch_gnt, mux_sel, ar_valid, r_ready, ch_done, len_err
   );

endinterface

// File: rtl/dma_read_arbiter_rr_pick.sv
// dma_rr_pick: combinational round-robin choice between the two channels.
// A lone requester always wins; when both request, the channel that did not
// finish the previous burst wins.
module dma_rr_pick (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       winner,
   output logic       any_req
);

   // Winner is ch1 whenever only ch1 asks, and alternates on contention.
   always_comb begin
      any_req = |req;
      winner  = req[1];
      if (req == 2'b11) begin
         winner = ~last_gnt;
      end
   end

endmodule

// File: rtl/dma_read_arbiter.sv
// dma_read_arbiter: round-robin arbiter giving one of two DMA read channels
// the shared AXI4 read port for a whole burst (AR handshake through RLAST).
// Drives the select of the external ARADDR/ARLEN muxes and checks the beat
// count of every burst against the ARLEN latched at grant.
// Optional build macro DMA_ARB_STATS_EN adds saturating per-channel grant
// counters (ch0_gnt_cnt / ch1_gnt_cnt, CNT_W bits each).
module dma_read_arbiter
   import dma_arb_pkg::*;
#(
   parameter int LEN_W = 8
`ifdef DMA_ARB_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   dma_read_arbiter_if.master    bus
`ifdef DMA_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]      ch0_gnt_cnt,
   output logic [CNT_W-1:0]      ch1_gnt_cnt
`endif
);

   arb_state_t       state;
   logic             last_gnt;
   logic [LEN_W-1:0] lat_len;
   logic [LEN_W:0]   beat_cnt;
   logic [LEN_W:0]   beat_next;
   logic [LEN_W:0]   beat_target;
   logic             winner;
   logic             any_req;
   logic             rbeat;

   dma_rr_pick u_pick (
      .req      (bus.ch_req),
      .last_gnt (last_gnt),
      .winner   (winner),
      .any_req  (any_req)
   );

   // The extra counter bit lets a runaway burst (len+2 beats at max ARLEN) still compare correctly.
   assign rbeat       = bus.r_valid & bus.r_ready;
   assign beat_next   = beat_cnt + (LEN_W+1)'(1);
   assign beat_target = {1'b0, lat_len} + (LEN_W+1)'(1);

   // Burst sequencer: grant in IDLE, hold ARVALID in ADDR, accept beats in DATA until RLAST.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         bus.ch_gnt   <= '0;
         bus.mux_sel  <= 1'b0;
         bus.ar_valid <= 1'b0;
         bus.r_ready  <= 1'b0;
         bus.ch_done  <= '0;
         bus.len_err  <= 1'b0;
         last_gnt     <= 1'b1;
         lat_len      <= '0;
         beat_cnt     <= '0;
      end else begin
         bus.ch_done <= '0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  bus.mux_sel  <= winner;
                  bus.ch_gnt   <= ch_onehot(winner);
                  lat_len      <= bus.ch_len[winner];
                  beat_cnt     <= '0;
                  bus.ar_valid <= 1'b1;
                  state        <= ADDR;
               end
            end
            ADDR: begin
               if (bus.ar_valid && bus.ar_ready) begin
                  bus.ar_valid <= 1'b0;
                  bus.r_ready  <= 1'b1;
                  state        <= DATA;
               end
            end
            DATA: begin
               if (rbeat) begin
                  beat_cnt <= beat_next;
                  if (bus.r_last) begin
                     bus.ch_done <= ch_onehot(bus.mux_sel);
                     last_gnt    <= bus.mux_sel;
                     bus.ch_gnt  <= '0;
                     bus.r_ready <= 1'b0;
                     state       <= IDLE;
                     if (beat_next != beat_target) begin
                        bus.len_err <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DMA_ARB_STATS_EN
   logic grant_now;

   assign grant_now = (state == IDLE) && any_req;

   // Count grants per channel on the IDLE->ADDR edge, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch0_gnt_cnt <= '0;
         ch1_gnt_cnt <= '0;
      end else if (grant_now) begin
         if (!winner && (ch0_gnt_cnt != '1)) begin
            ch0_gnt_cnt <= ch0_gnt_cnt + CNT_W'(1);
         end
         if (winner && (ch1_gnt_cnt != '1)) begin
            ch1_gnt_cnt <= ch1_gnt_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_dma_read_arbiter.sv
// tb_dma_read_arbiter: self-checking bench for dma_read_arbiter.
// A table of burst-level vectors, hand-written cycle sequences for the
// corner cases, and a randomized run checked against a burst-level
// round-robin model. Grant statistics are exercised when DMA_ARB_STATS_EN
// is defined (counters built 2 bits wide so saturation is reachable).
module tb_dma_read_arbiter;
   import dma_arb_pkg::*;

   localparam int TB_CNT_W = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   dma_read_arbiter_if #(.LEN_W(8)) bus ();

`ifdef DMA_ARB_STATS_EN
   logic [TB_CNT_W-1:0] ch0_cnt;
   logic [TB_CNT_W-1:0] ch1_cnt;
`endif

   dma_read_arbiter #(
      .LEN_W (8)
`ifdef DMA_ARB_STATS_EN
      ,
      .CNT_W (TB_CNT_W)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef DMA_ARB_STATS_EN
      ,
      .ch0_gnt_cnt (ch0_cnt),
      .ch1_gnt_cnt (ch1_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic [7:0] len0;
      logic [7:0] len1;
      int         ar_delay;
      int         beats;
      bit         drop;
      int         exp_ch;
      logic [1:0] exp_done;
      logic       exp_lerr;
   } vec_t;

   vec_t vecs[11];

   int compared   = 0;
   int mismatched = 0;

   int         gch;
   int         lat;
   logic [1:0] done;
   logic       lerr;
   bit         proto_ok;

   int         model_last;
   logic       model_lerr;
   logic [1:0] r_req;
   logic [7:0] r_l0;
   logic [7:0] r_l1;
   int         r_win;
   int         r_len;
   int         r_beats;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic resetDut();
      rst          = 1'b1;
      bus.ch_req   = '0;
      bus.ch_len   = '0;
      bus.ar_ready = 1'b0;
      bus.r_valid  = 1'b0;
      bus.r_last   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [31:0] out_vec();
      return {24'd0, bus.ch_gnt, bus.mux_sel, bus.ar_valid, bus.r_ready, bus.ch_done, bus.len_err};
   endfunction

   // Runs one whole burst from an IDLE negedge; returns grant, latency, done pulse, len_err and a protocol verdict.
   task automatic applyStimulus(input logic [1:0] req, input logic [7:0] len0, input logic [7:0] len1,
                                input int ar_delay, input int beats, input int gap_max, input bit drop,
                                output int o_gch, output int o_lat, output logic [1:0] o_done,
                                output logic o_lerr, output bit o_ok);
      logic [1:0] gnt0;
      logic       sel0;
      o_ok = 1'b1; o_gch = -1; o_lat = 0; o_done = '0; o_lerr = 1'b0;
      bus.ch_req    = req;
      bus.ch_len[0] = len0;
      bus.ch_len[1] = len1;
      bus.ar_ready  = 1'b0;
      bus.r_valid   = 1'b0;
      bus.r_last    = 1'b0;
      while (!bus.ar_valid && o_lat < 8) begin
         tick();
         o_lat++;
      end
      if (!bus.ar_valid) begin
         checkOutput("ar_valid_timeout", 32'd0, 32'd1);
         o_ok = 1'b0;
         bus.ch_req = '0;
         return;
      end
      gnt0 = bus.ch_gnt;
      sel0 = bus.mux_sel;
      if (gnt0 == 2'b01) o_gch = 0;
      else if (gnt0 == 2'b10) o_gch = 1;
      else o_ok = 1'b0;
      if (int'(sel0) != o_gch || bus.r_ready) o_ok = 1'b0;
      // R-channel noise while waiting on ARREADY must be ignored.
      for (int i = 0; i < ar_delay; i++) begin
         bus.r_valid = 1'b1;
         bus.r_last  = 1'b1;
         tick();
         if (!bus.ar_valid || bus.r_ready || bus.ch_done != 2'b00 ||
             bus.ch_gnt != gnt0 || bus.mux_sel != sel0) o_ok = 1'b0;
      end
      bus.r_valid  = 1'b0;
      bus.r_last   = 1'b0;
      bus.ar_ready = 1'b1;
      tick();
      bus.ar_ready = 1'b0;
      if (bus.ar_valid || !bus.r_ready) o_ok = 1'b0;
      if (drop) bus.ch_req = '0;
      for (int b = 0; b < beats; b++) begin
         int gaps;
         gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         for (int g = 0; g < gaps; g++) begin
            tick();
            if (!bus.r_ready || bus.ch_done != 2'b00) o_ok = 1'b0;
         end
         if (!bus.r_ready || bus.ar_valid || bus.ch_done != 2'b00 ||
             bus.ch_gnt != gnt0 || bus.mux_sel != sel0) o_ok = 1'b0;
         bus.r_valid = 1'b1;
         bus.r_last  = (b == beats - 1);
         tick();
         bus.r_valid = 1'b0;
         bus.r_last  = 1'b0;
      end
      o_done = bus.ch_done;
      o_lerr = bus.len_err;
      if (bus.r_ready || bus.ar_valid || bus.ch_gnt != 2'b00 || bus.mux_sel != sel0) o_ok = 1'b0;
      bus.ch_req = '0;
   endtask

   // Top-level test sequence.
   initial begin
      vecs[0]  = '{2'b01, 8'd3,   8'd0,   0, 4,   1'b0, 0, 2'b01, 1'b0};
      vecs[1]  = '{2'b11, 8'd2,   8'd2,   0, 3,   1'b0, 1, 2'b10, 1'b0};
      vecs[2]  = '{2'b11, 8'd2,   8'd2,   0, 3,   1'b0, 0, 2'b01, 1'b0};
      vecs[3]  = '{2'b11, 8'd2,   8'd2,   0, 3,   1'b0, 1, 2'b10, 1'b0};
      vecs[4]  = '{2'b10, 8'd0,   8'd5,   5, 6,   1'b0, 1, 2'b10, 1'b0};
      vecs[5]  = '{2'b10, 8'd0,   8'd1,   1, 2,   1'b1, 1, 2'b10, 1'b0};
      vecs[6]  = '{2'b11, 8'd0,   8'd0,   0, 1,   1'b0, 0, 2'b01, 1'b0};
      vecs[7]  = '{2'b01, 8'd7,   8'd0,   0, 5,   1'b0, 0, 2'b01, 1'b1};
      vecs[8]  = '{2'b11, 8'd1,   8'd1,   2, 2,   1'b0, 1, 2'b10, 1'b1};
      vecs[9]  = '{2'b01, 8'd255, 8'd0,   0, 256, 1'b0, 0, 2'b01, 1'b1};
      vecs[10] = '{2'b11, 8'd3,   8'd3,   0, 4,   1'b0, 1, 2'b10, 1'b1};

      tick();
      resetDut();
      checkOutput("reset_outputs", out_vec(), 32'd0);
`ifdef DMA_ARB_STATS_EN
      checkOutput("reset_stats", {28'd0, ch0_cnt, ch1_cnt}, 32'd0);
`endif

      // Single ch0 burst with ARREADY already high, cycle by cycle.
      bus.ch_req    = 2'b01;
      bus.ch_len[0] = 8'd3;
      bus.ar_ready  = 1'b1;
      tick();
      checkOutput("t1_ar_valid", {30'd0, bus.ar_valid, bus.r_ready}, 32'h2);
      checkOutput("t1_gnt", {30'd0, bus.ch_gnt}, 32'h1);
      tick();
      bus.ar_ready = 1'b0;
      checkOutput("t1_data_phase", {30'd0, bus.ar_valid, bus.r_ready}, 32'h1);
      for (int b = 0; b < 4; b++) begin
         bus.r_valid = 1'b1;
         bus.r_last  = (b == 3);
         tick();
      end
      bus.r_valid = 1'b0;
      bus.r_last  = 1'b0;
      bus.ch_req  = 2'b00;
      checkOutput("t1_done", {29'd0, bus.ch_done, bus.len_err}, 32'h2);
      tick();
      checkOutput("t1_done_one_cycle", {30'd0, bus.ch_done}, 32'h0);

      resetDut();
      for (int v = 0; v < 11; v++) begin
         applyStimulus(vecs[v].req, vecs[v].len0, vecs[v].len1, vecs[v].ar_delay, vecs[v].beats,
                       0, vecs[v].drop, gch, lat, done, lerr, proto_ok);
         checkOutput($sformatf("vec%0d_grant", v), gch, vecs[v].exp_ch);
         checkOutput($sformatf("vec%0d_latency", v), lat, 32'd1);
         checkOutput($sformatf("vec%0d_done", v), {30'd0, done}, {30'd0, vecs[v].exp_done});
         checkOutput($sformatf("vec%0d_len_err", v), {31'd0, lerr}, {31'd0, vecs[v].exp_lerr});
         checkOutput($sformatf("vec%0d_protocol", v), {31'd0, proto_ok}, 32'd1);
      end

      // Reset in the middle of a ch1 data phase must also forget the round-robin history.
      resetDut();
      applyStimulus(2'b01, 8'd0, 8'd0, 0, 1, 0, 1'b0, gch, lat, done, lerr, proto_ok);
      checkOutput("rst_pre_burst", gch, 32'd0);
      bus.ch_req    = 2'b11;
      bus.ch_len[0] = 8'd3;
      bus.ch_len[1] = 8'd3;
      tick();
      checkOutput("rst_pre_gnt", {30'd0, bus.ch_gnt}, 32'h2);
      bus.ar_ready = 1'b1;
      tick();
      bus.ar_ready = 1'b0;
      bus.r_valid  = 1'b1;
      tick();
      bus.r_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst_mid_outputs", out_vec(), 32'd0);
      tick();
      checkOutput("rst_next_gnt", {30'd0, bus.ch_gnt}, 32'h1);

      // Random bursts against a burst-level round-robin model.
      resetDut();
      model_last = 1;
      model_lerr = 1'b0;
      for (int n = 0; n < 40; n++) begin
         r_req = 2'($urandom_range(3, 1));
         r_l0  = 8'($urandom_range(7, 0));
         r_l1  = 8'($urandom_range(7, 0));
         if (r_req == 2'b11) r_win = 1 - model_last;
         else r_win = (r_req == 2'b10) ? 1 : 0;
         r_len   = (r_win == 1) ? int'(r_l1) : int'(r_l0);
         r_beats = ($urandom_range(7, 0) == 0) ? int'($urandom_range(9, 1)) : r_len + 1;
         applyStimulus(r_req, r_l0, r_l1, int'($urandom_range(3, 0)), r_beats, 2,
                       ($urandom_range(3, 0) == 0), gch, lat, done, lerr, proto_ok);
         if (r_beats != r_len + 1) model_lerr = 1'b1;
         model_last = r_win;
         checkOutput($sformatf("rnd%0d_grant", n), gch, r_win);
         checkOutput($sformatf("rnd%0d_done", n), {30'd0, done}, (r_win == 1) ? 32'h2 : 32'h1);
         checkOutput($sformatf("rnd%0d_len_err", n), {31'd0, lerr}, {31'd0, model_lerr});
         checkOutput($sformatf("rnd%0d_latency", n), lat, 32'd1);
         checkOutput($sformatf("rnd%0d_protocol", n), {31'd0, proto_ok}, 32'd1);
      end

`ifdef DMA_ARB_STATS_EN
      // Grant statistics: 3 ch0 / 2 ch1 grants, then ch0 pushed past saturation.
      resetDut();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(2'b11, 8'd0, 8'd0, 0, 1, 0, 1'b0, gch, lat, done, lerr, proto_ok);
      end
      checkOutput("stats_ch0", {30'd0, ch0_cnt}, 32'd3);
      checkOutput("stats_ch1", {30'd0, ch1_cnt}, 32'd2);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(2'b01, 8'd0, 8'd0, 0, 1, 0, 1'b0, gch, lat, done, lerr, proto_ok);
      end
      checkOutput("stats_ch0_sat", {30'd0, ch0_cnt}, 32'd3);
      checkOutput("stats_ch1_hold", {30'd0, ch1_cnt}, 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
